// File: rtl/shift_reg_ctrl.sv
// Round-robin 2-way arbiter and load/shift sequencer for a parallel-load right-shift register.
// One granted word is loaded, then shifted out LSB first for SHIFTS cycles before the next grant.
module shift_reg_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SHIFTS = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic             sr_load,
    output logic             sr_ena,
    output logic [WIDTH-1:0] sr_in,
    input  logic [WIDTH-1:0] sr_q,
    output logic             ser_valid,
    output logic             ser_bit,
    output logic             ser_owner,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             grant_any;
    logic             grant_idx;
    logic             unused_sr_q;

    // Grant is only offered in IDLE; a tie goes to whoever did not own the last transfer.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 1'b0;
        if (state == IDLE && !areset && req_valid != 2'b00) begin
            grant_any = 1'b1;
            if (req_valid == 2'b11) begin
                grant_idx = ~last_grant;
            end else begin
                grant_idx = req_valid[1];
            end
        end
    end

    assign req_ready = grant_any ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign ser_bit   = ser_valid & sr_q[0];

    // Only the LSB of the register is observed; the upper bits belong to the register itself.
    assign unused_sr_q = ^sr_q[WIDTH-1:1];

    always_ff @(posedge clk) begin
        if (areset) begin
            state      <= IDLE;
            cnt        <= '0;
            sr_in      <= '0;
            ser_owner  <= 1'b0;
            last_grant <= 1'b1;
            sr_load    <= 1'b0;
            sr_ena     <= 1'b0;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        sr_in     <= grant_idx ? req_data1 : req_data0;
                        ser_owner <= grant_idx;
                        sr_load   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    sr_load   <= 1'b0;
                    sr_ena    <= 1'b1;
                    ser_valid <= 1'b1;
                    cnt       <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(SHIFTS - 1)) begin
                        sr_ena    <= 1'b0;
                        ser_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    last_grant <= ser_owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: two instances (SHIFTS=4 and SHIFTS=2), each driving a behavioural shift register.
// Expected serial bits are queued at each handshake and popped as the DUT shifts them out.
module tb_shift_reg_ctrl;

    logic       clk;
    logic       areset;
    logic [1:0] req_valid;
    logic [3:0] req_data0;
    logic [3:0] req_data1;

    logic [1:0] ready_a, ready_b;
    logic       load_a, load_b, ena_a, ena_b;
    logic [3:0] in_a, in_b;
    logic [3:0] q_a, q_b;
    logic       sval_a, sval_b, sbit_a, sbit_b, own_a, own_b;
    logic       busy_a, busy_b, done_a, done_b;

    bit         use_b;
    logic [1:0] m_ready;
    logic       m_load, m_ena, m_valid, m_bit, m_owner, m_busy, m_done;
    logic [3:0] m_in;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    logic [1:0] sb[$];

    typedef struct {
        bit         rst;
        logic [1:0] valid;
        logic [3:0] d0;
        logic [3:0] d1;
        int         owner;
        bit         hold;
    } vec_t;

    vec_t vecs[6];
    int   t_hs[6];

    shift_reg_ctrl #(.WIDTH(4), .SHIFTS(4)) dut_a (
        .clk(clk), .areset(areset), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(ready_a),
        .sr_load(load_a), .sr_ena(ena_a), .sr_in(in_a), .sr_q(q_a),
        .ser_valid(sval_a), .ser_bit(sbit_a), .ser_owner(own_a),
        .busy(busy_a), .done(done_a)
    );

    shift_reg_ctrl #(.WIDTH(4), .SHIFTS(2)) dut_b (
        .clk(clk), .areset(areset), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(ready_b),
        .sr_load(load_b), .sr_ena(ena_b), .sr_in(in_b), .sr_q(q_b),
        .ser_valid(sval_b), .ser_bit(sbit_b), .ser_owner(own_b),
        .busy(busy_b), .done(done_b)
    );

    // Behavioural shift registers: load wins over enable, right shift with zero fill.
    always @(posedge clk) begin
        if (load_a) q_a <= in_a;
        else if (ena_a) q_a <= {1'b0, q_a[3:1]};
        if (load_b) q_b <= in_b;
        else if (ena_b) q_b <= {1'b0, q_b[3:1]};
        cyc <= cyc + 1;
    end

    assign m_ready = use_b ? ready_b : ready_a;
    assign m_load  = use_b ? load_b  : load_a;
    assign m_ena   = use_b ? ena_b   : ena_a;
    assign m_in    = use_b ? in_b    : in_a;
    assign m_valid = use_b ? sval_b  : sval_a;
    assign m_bit   = use_b ? sbit_b  : sbit_a;
    assign m_owner = use_b ? own_b   : own_a;
    assign m_busy  = use_b ? busy_b  : busy_a;
    assign m_done  = use_b ? done_b  : done_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [3:0] d0, input logic [3:0] d1);
        req_valid = valid;
        req_data0 = d0;
        req_data1 = d1;
    endtask

    task automatic applyReset();
        areset = 1'b1;
        applyStimulus(2'b00, 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
        sb.delete();
    endtask

    task automatic waitHandshake(output bit got);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (m_ready != 2'b00) got = 1'b1;
        end
        if (!got) checkOutput("handshake_timeout", 0, 1);
    endtask

    task automatic checkShiftBit(input bit hold);
        logic [1:0] exp;
        checkOutput("sr_ena", int'(m_ena), 1);
        checkOutput("ser_valid", int'(m_valid), 1);
        checkOutput("sr_load_in_shift", int'(m_load), 0);
        if (hold) checkOutput("ready_blocked", int'(m_ready), 0);
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
        end else begin
            exp = sb.pop_front();
            checkOutput("ser_owner", int'(m_owner), int'(exp[1]));
            checkOutput("ser_bit", int'(m_bit), int'(exp[0]));
        end
    endtask

    // One complete transfer, checked cycle by cycle from the handshake through done.
    task automatic runTransfer(input logic [1:0] valid, input logic [3:0] d0, input logic [3:0] d1,
                               input int owner, input bit hold, input int shifts, output int t);
        logic [3:0] word;
        bit got;
        t = -1;
        applyStimulus(valid, d0, d1);
        waitHandshake(got);
        if (!got) return;
        t = cyc;
        checkOutput("req_ready", int'(m_ready), owner == 1 ? 2 : 1);
        word = (owner == 1) ? d1 : d0;
        for (int k = 0; k < shifts; k++) sb.push_back({owner[0], word[k]});
        @(posedge clk);
        #1 applyStimulus(hold ? valid : 2'b00, ~d0, ~d1);
        @(negedge clk);
        checkOutput("sr_load", int'(m_load), 1);
        checkOutput("ena_in_load", int'(m_ena), 0);
        checkOutput("busy", int'(m_busy), 1);
        checkOutput("sr_in", int'(m_in), int'(word));
        if (hold) checkOutput("ready_blocked", int'(m_ready), 0);
        for (int k = 0; k < shifts; k++) begin
            @(negedge clk);
            checkShiftBit(hold);
        end
        @(negedge clk);
        checkOutput("done", int'(m_done), 1);
        checkOutput("ena_in_done", int'(m_ena), 0);
        checkOutput("valid_in_done", int'(m_valid), 0);
        checkOutput("sr_in_hold", int'(m_in), int'(word));
        @(posedge clk);
        #1;
        if (!hold) begin
            @(negedge clk);
            checkOutput("done_pulse_end", int'(m_done), 0);
            checkOutput("busy_idle", int'(m_busy), 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit got;
        int t;

        vecs[0] = '{1'b1, 2'b01, 4'b1010, 4'b0000, 0, 1'b0};
        vecs[1] = '{1'b1, 2'b11, 4'b0011, 4'b1100, 0, 1'b1};
        vecs[2] = '{1'b0, 2'b11, 4'b0011, 4'b1100, 1, 1'b1};
        vecs[3] = '{1'b0, 2'b11, 4'b0011, 4'b1100, 0, 1'b0};
        vecs[4] = '{1'b0, 2'b01, 4'b0101, 4'b1111, 0, 1'b1};
        vecs[5] = '{1'b0, 2'b01, 4'b0101, 4'b1111, 0, 1'b0};

        use_b = 1'b0;
        areset = 1'b1;
        applyStimulus(2'b11, 4'hF, 4'hF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst_ready", int'(m_ready), 0);
            checkOutput("rst_load", int'(m_load), 0);
            checkOutput("rst_ena", int'(m_ena), 0);
            checkOutput("rst_busy", int'(m_busy), 0);
            checkOutput("rst_done", int'(m_done), 0);
        end
        @(posedge clk);
        #1 areset = 1'b0;
        applyStimulus(2'b00, 4'h0, 4'h0);
        @(negedge clk);
        checkOutput("idle_ready", int'(m_ready), 0);
        checkOutput("idle_valid", int'(m_valid), 0);
        checkOutput("idle_bit", int'(m_bit), 0);
        checkOutput("idle_sr_in", int'(m_in), 0);
        checkOutput("idle_owner", int'(m_owner), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rst) applyReset();
            runTransfer(vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].owner, vecs[i].hold, 4, t);
            t_hs[i] = t;
        end
        checkOutput("rr_gap_1", t_hs[2] - t_hs[1], 7);
        checkOutput("rr_gap_2", t_hs[3] - t_hs[2], 7);
        checkOutput("lone_gap", t_hs[5] - t_hs[4], 7);

        // Abort during the second shift cycle.
        applyReset();
        applyStimulus(2'b01, 4'b1010, 4'b0000);
        waitHandshake(got);
        if (got) begin
            for (int k = 0; k < 4; k++) sb.push_back({1'b0, k[0]});
            @(posedge clk);
            #1 applyStimulus(2'b00, 4'h0, 4'h0);
            @(negedge clk);
            checkOutput("abort_load", int'(m_load), 1);
            @(negedge clk);
            checkShiftBit(1'b0);
            @(posedge clk);
            #1 areset = 1'b1;
            @(negedge clk);
            checkShiftBit(1'b0);
            @(posedge clk);
            #1 areset = 1'b0;
            sb.delete();
            @(negedge clk);
            checkOutput("abort_ena", int'(m_ena), 0);
            checkOutput("abort_valid", int'(m_valid), 0);
            checkOutput("abort_load_off", int'(m_load), 0);
            checkOutput("abort_busy", int'(m_busy), 0);
            for (int k = 0; k < 4; k++) begin
                checkOutput("abort_no_done", int'(m_done), 0);
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end
        runTransfer(2'b01, 4'b1001, 4'b0000, 0, 1'b0, 4, t);

        // Second instance with only two shifts per word.
        use_b = 1'b1;
        applyReset();
        runTransfer(2'b01, 4'b0110, 4'b0000, 0, 1'b0, 2, t);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
